// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One product/quotient bit per cycle, followed by a sign-fix cycle that writes HI/LO.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] mt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [WIDTH-1:0] raw_a_q, raw_a_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div_zero_q, div_zero_d;

   logic             signed_op, neg_a, neg_b;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   sum, upper, diff;
   logic [PW-1:0]    prod_neg;
   logic [WIDTH-1:0] quo, rem;

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Next-state, datapath and output logic
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      prod_d     = prod_q;
      opd_d      = opd_q;
      raw_a_d    = raw_a_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;

      signed_op = ~op[0];
      neg_a     = signed_op & src_a[WIDTH-1];
      neg_b     = signed_op & src_b[WIDTH-1];
      abs_a     = neg_a ? (~src_a) + WIDTH'(1) : src_a;
      abs_b     = neg_b ? (~src_b) + WIDTH'(1) : src_b;

      sum      = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opd_q} : '0);
      upper    = prod_q[PW-2:WIDTH-1] == prod_q[PW-2:WIDTH-1] ? prod_q[PW-1:WIDTH-1] : '0;
      diff     = upper - {1'b0, opd_q};
      prod_neg = (~prod_q) + PW'(1);
      quo      = neg_res_q ? (~prod_q[WIDTH-1:0]) + WIDTH'(1) : prod_q[WIDTH-1:0];
      rem      = neg_rem_q ? (~prod_q[PW-1:WIDTH]) + WIDTH'(1) : prod_q[PW-1:WIDTH];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_CALC;
               busy_d     = 1'b1;
               cnt_d      = '0;
               is_div_d   = op[1];
               neg_res_d  = neg_a ^ neg_b;
               neg_rem_d  = neg_a;
               raw_a_d    = src_a;
               div_zero_d = op[1] & (src_b == '0);
               // Multiply adds |a| into the top half; divide subtracts |b|.
               opd_d      = op[1] ? abs_b : abs_a;
               prod_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            end else begin
               if (mthi_we) hi_d = mt_data;
               if (mtlo_we) lo_d = mt_data;
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               if (!diff[WIDTH]) prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
               else              prod_d = {upper[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end else begin
               prod_d = {sum, prod_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = neg_res_q ? prod_neg[PW-1:WIDTH]  : prod_q[PW-1:WIDTH];
               lo_d = neg_res_q ? prod_neg[WIDTH-1:0]   : prod_q[WIDTH-1:0];
            end else if (div_zero_q) begin
               hi_d = raw_a_q;
               lo_d = '1;
            end else begin
               hi_d = rem;
               lo_d = quo;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         prod_q     <= '0;
         opd_q      <= '0;
         raw_a_q    <= '0;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         prod_q     <= prod_d;
         opd_q      <= opd_d;
         raw_a_q    <= raw_a_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned
// results, divide-by-zero, ignored start/MT while busy, async reset abort.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fails  = 0;
   logic [31:0] model_hi = 32'h0;
   logic [31:0] model_lo = 32'h0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .mthi_we (mthi_we),
      .mtlo_we (mtlo_we),
      .mt_data (mt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // mode 0: plain; 1: start pulse at cycle 5 and mtlo_we at cycle 10; 2: mthi_we with the start
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int mode);
      int n;
      int busy_cycles;
      bit seen;
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      if (mode == 2) begin mthi_we = 1'b1; mt_data = 32'h1111_1111; end
      @(posedge clk); #1;
      start = 1'b0; mthi_we = 1'b0;
      check({tag, " busy after start"}, 64'(busy), 64'(1));
      busy_cycles = busy ? 1 : 0;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (busy) busy_cycles++;
         if (mode == 1 && n == 5)  begin start = 1'b1; op = 2'b00; src_a = 32'h1234; src_b = 32'h3; end
         if (mode == 1 && n == 6)  start = 1'b0;
         if (mode == 1 && n == 10) begin mtlo_we = 1'b1; mt_data = 32'hDEAD_BEEF; end
         if (mode == 1 && n == 11) mtlo_we = 1'b0;
         if (n == 16) check({tag, " hi/lo held mid-op"}, {hi, lo}, {model_hi, model_lo});
         if (done) seen = 1;
      end
      check({tag, " done edge after start"}, 64'(n), 64'(33));
      check({tag, " busy cycles"}, 64'(busy_cycles), 64'(33));
      check({tag, " busy low at done"}, 64'(busy), 64'(0));
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      model_hi = eh; model_lo = el;
      @(posedge clk); #1;
      check({tag, " done single pulse"}, 64'(done), 64'(0));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
      #12;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset hi",   64'(hi),   64'(0));
      check("reset lo",   64'(lo),   64'(0));
      @(negedge clk); reset = 1'b1;

      run_op("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run_op("MULT -3*7",     2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      run_op("MULT min*min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
      run_op("DIVU 100/7",    2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 0);
      run_op("DIV -7/2",      2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("DIV min/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
      run_op("DIVU by zero",  2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0);
      run_op("DIV -8 by zero",2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0);
      run_op("DIVU ignore",   2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1);
      run_op("start beats MT",2'b01, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 2);

      // Async reset in the middle of a MULTU
      @(negedge clk);
      op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort hi",   64'(hi),   64'(0));
      check("abort lo",   64'(lo),   64'(0));
      @(negedge clk); reset = 1'b1;

      @(negedge clk); mthi_we = 1'b1; mt_data = 32'hA5A5_A5A5;
      @(posedge clk); #1; mthi_we = 1'b0;
      check("MTHI hi", 64'(hi), 64'(32'hA5A5_A5A5));
      check("MTHI lo", 64'(lo), 64'(0));
      check("idle after abort", 64'(busy), 64'(0));

      @(negedge clk); mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h0123_4567;
      @(posedge clk); #1; mthi_we = 1'b0; mtlo_we = 1'b0;
      check("MT both hi", 64'(hi), 64'(32'h0123_4567));
      check("MT both lo", 64'(lo), 64'(32'h0123_4567));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
